// File: rtl/ov7670_stream_if.sv
// ov7670_stream_if: parallel camera video bus (OV7670-style output).
//   pclk  - pixel clock
//   vsync - frame sync, active high
//   href  - line valid, high while active bytes are on d
//   d     - pixel byte, stable around each pclk rise
// master modport: the video source; slave modport: the capture side.
interface ov7670_stream_if;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] d;

    modport master (output pclk, output vsync, output href, output d);
    modport slave  (input  pclk, input  vsync, input  href, input  d);
endinterface

// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen: emulates the OV7670 parallel video output from the system clock.
// Produces color-bar or ramp frames in RGB565 or YUV422 with the sensor's byte order.
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   en          - free-run frames (sampled at frame start only)
//   rgbmode     - 1: RGB565, 0: YUV422 (latched at frame start)
//   pattern     - 0: 8 color bars, 1: ramp (latched at frame start)
//   vid         - video bus (pclk/vsync/href/d), master side
//   frame_done  - 1-clk pulse when the vertical front porch of a frame ends
//   busy        - high whenever the generator is not idle
module ov7670_stream_gen #(
    parameter int unsigned c_img_cols    = 320,
    parameter int unsigned c_img_rows    = 240,
    parameter int unsigned c_pclk_div    = 2,
    parameter int unsigned c_hblank      = 144,
    parameter int unsigned c_vsync_lines = 3,
    parameter int unsigned c_vbp         = 17,
    parameter int unsigned c_vfp         = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   rgbmode,
    input  logic                   pattern,
    ov7670_stream_if.master        vid,
    output logic                   frame_done,
    output logic                   busy
);

    localparam int unsigned LINE_LEN  = 2 * c_img_cols + c_hblank;
    localparam int unsigned ACT_BYTES = 2 * c_img_cols;
    localparam int unsigned HW        = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int unsigned MAX_AB    = (c_vsync_lines > c_vbp) ? c_vsync_lines : c_vbp;
    localparam int unsigned MAX_CD    = (c_img_rows > c_vfp) ? c_img_rows : c_vfp;
    localparam int unsigned MAX_L     = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned LW        = (MAX_L > 1) ? $clog2(MAX_L) : 1;
    localparam int unsigned DW        = (c_pclk_div > 1) ? $clog2(c_pclk_div) : 1;
    localparam int unsigned BAR_W     = c_img_cols / 8;
    localparam int unsigned BW        = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_ACTIVE,
        S_VFP
    } state_t;

    state_t          state;
    logic [DW-1:0]   div_cnt;
    logic [HW-1:0]   hcnt;
    logic [LW-1:0]   lcnt;
    logic [2:0]      bar_idx;
    logic [BW-1:0]   bar_cnt;
    logic [7:0]      frame_cnt;
    logic            rgb_l;
    logic            pat_l;
    logic            pclk_q;
    logic            vsync_q;
    logic            href_q;
    logic [7:0]      d_q;

    logic            tick_c;
    logic            fall_tick_c;
    state_t          nxt_state_c;
    logic [HW-1:0]   nxt_hcnt_c;
    logic [LW-1:0]   nxt_lcnt_c;
    logic [2:0]      nxt_bar_idx_c;
    logic [BW-1:0]   nxt_bar_cnt_c;
    logic            load_c;
    logic            done_c;
    logic            href_c;
    logic [7:0]      byte_c;
    int unsigned     lines_c;
    logic [7:0]      col_c;
    logic [7:0]      row_c;
    logic [15:0]     rgb_val_c;
    logic [7:0]      luma_c;

    assign vid.pclk  = pclk_q;
    assign vid.vsync = vsync_q;
    assign vid.href  = href_q;
    assign vid.d     = d_q;

    // Color-bar RGB565 value for bar index 0..7
    function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // Color-bar luma for bar index 0..7
    function automatic logic [7:0] bar_luma(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'd235;
            3'd1:    return 8'd210;
            3'd2:    return 8'd170;
            3'd3:    return 8'd145;
            3'd4:    return 8'd106;
            3'd5:    return 8'd81;
            3'd6:    return 8'd41;
            default: return 8'd16;
        endcase
    endfunction

    assign tick_c      = (div_cnt == DW'(c_pclk_div - 1));
    assign fall_tick_c = tick_c & pclk_q;

    // Next position in the frame; outputs are registered from this position so that
    // vsync/href/d always agree with the state/counters they were produced from.
    always_comb begin
        nxt_state_c = state;
        nxt_hcnt_c  = hcnt;
        nxt_lcnt_c  = lcnt;
        load_c      = 1'b0;
        done_c      = 1'b0;
        case (state)
            S_VSYNC:  lines_c = c_vsync_lines;
            S_VBP:    lines_c = c_vbp;
            S_ACTIVE: lines_c = c_img_rows;
            default:  lines_c = c_vfp;
        endcase

        if (state == S_IDLE) begin
            if (en) begin
                nxt_state_c = S_VSYNC;
                nxt_hcnt_c  = '0;
                nxt_lcnt_c  = '0;
                load_c      = 1'b1;
            end
        end else if (hcnt == HW'(LINE_LEN - 1)) begin
            nxt_hcnt_c = '0;
            nxt_lcnt_c = lcnt + LW'(1);
            if (lcnt == LW'(lines_c - 1)) begin
                nxt_lcnt_c = '0;
                case (state)
                    S_VSYNC:  nxt_state_c = S_VBP;
                    S_VBP:    nxt_state_c = S_ACTIVE;
                    S_ACTIVE: nxt_state_c = S_VFP;
                    default: begin
                        done_c = 1'b1;
                        if (en) begin
                            nxt_state_c = S_VSYNC;
                            load_c      = 1'b1;
                        end else begin
                            nxt_state_c = S_IDLE;
                        end
                    end
                endcase
            end
        end else begin
            nxt_hcnt_c = hcnt + HW'(1);
        end
    end

    // Bar tracking: a bar counter that steps every BAR_W pixels replaces col/BAR_W
    always_comb begin
        nxt_bar_idx_c = bar_idx;
        nxt_bar_cnt_c = bar_cnt;
        if (nxt_hcnt_c == '0) begin
            nxt_bar_idx_c = '0;
            nxt_bar_cnt_c = '0;
        end else if (hcnt[0]) begin
            if (bar_cnt == BW'(BAR_W - 1)) begin
                nxt_bar_idx_c = bar_idx + 3'd1;
                nxt_bar_cnt_c = '0;
            end else begin
                nxt_bar_cnt_c = bar_cnt + BW'(1);
            end
        end
    end

    // Pixel byte for the next position
    always_comb begin
        col_c     = 8'(nxt_hcnt_c >> 1);
        row_c     = 8'(nxt_lcnt_c);
        rgb_val_c = pat_l ? {col_c[4:0], row_c[5:0], frame_cnt[4:0]} : bar_rgb(nxt_bar_idx_c);
        luma_c    = pat_l ? 8'(col_c + row_c) : bar_luma(nxt_bar_idx_c);
        href_c    = (nxt_state_c == S_ACTIVE) && (nxt_hcnt_c < HW'(ACT_BYTES));
        if (!href_c) begin
            byte_c = 8'h00;
        end else if (rgb_l) begin
            byte_c = nxt_hcnt_c[0] ? rgb_val_c[7:0] : rgb_val_c[15:8];
        end else begin
            // U,Y,V,Y with neutral chroma: every even byte is 0x80
            byte_c = nxt_hcnt_c[0] ? luma_c : 8'h80;
        end
    end

    // Pixel clock divider, frame FSM and registered video outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            hcnt       <= '0;
            lcnt       <= '0;
            bar_idx    <= '0;
            bar_cnt    <= '0;
            frame_cnt  <= '0;
            rgb_l      <= 1'b0;
            pat_l      <= 1'b0;
            pclk_q     <= 1'b0;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            d_q        <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tick_c) begin
                div_cnt <= '0;
                pclk_q  <= ~pclk_q;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end

            if (fall_tick_c) begin
                state   <= nxt_state_c;
                hcnt    <= nxt_hcnt_c;
                lcnt    <= nxt_lcnt_c;
                bar_idx <= nxt_bar_idx_c;
                bar_cnt <= nxt_bar_cnt_c;
                if (load_c) begin
                    rgb_l <= rgbmode;
                    pat_l <= pattern;
                end
                if (done_c) begin
                    frame_cnt  <= frame_cnt + 8'd1;
                    frame_done <= 1'b1;
                end
                vsync_q <= (nxt_state_c == S_VSYNC);
                href_q  <= href_c;
                d_q     <= byte_c;
                busy    <= (nxt_state_c != S_IDLE);
            end
        end
    end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// tb_ov7670_stream_gen: self-checking bench for ov7670_stream_gen.
// A capture-side monitor rebuilds every line from the pclk/vsync/href/d stream and
// compares it to pixel values computed from the frame-format rules; directed table
// vectors and hand-written sequences cover the corner cases.
module tb_ov7670_stream_gen;

    localparam int COLS   = 16;
    localparam int ROWS   = 4;
    localparam int DIV    = 1;
    localparam int HB     = 8;
    localparam int VS     = 1;
    localparam int VBP    = 1;
    localparam int VFP    = 1;
    localparam int LINE   = 2 * COLS + HB;
    localparam int ABYTES = 2 * COLS;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic en      = 1'b0;
    logic rgbmode = 1'b0;
    logic pattern = 1'b0;
    logic frame_done;
    logic busy;

    ov7670_stream_if vid ();

    ov7670_stream_gen #(
        .c_img_cols   (COLS),
        .c_img_rows   (ROWS),
        .c_pclk_div   (DIV),
        .c_hblank     (HB),
        .c_vsync_lines(VS),
        .c_vbp        (VBP),
        .c_vfp        (VFP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rgbmode   (rgbmode),
        .pattern   (pattern),
        .vid       (vid),
        .frame_done(frame_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int bar_rgb_t [8] = '{32'hFFFF, 32'hFFE0, 32'h07FF, 32'h07E0, 32'hF81F, 32'hF800, 32'h001F, 32'h0000};
    int luma_t    [8] = '{235, 210, 170, 145, 106, 81, 41, 16};

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Expected byte b of an active line, from the format rules
    function automatic logic [7:0] exp_byte(input bit rgb, input bit pat, input int fc,
                                            input int row, input int b);
        int col;
        int bar;
        int v;
        col = b / 2;
        bar = col / (COLS / 8);
        if (rgb) begin
            if (pat) v = ((col % 32) << 11) | ((row % 64) << 5) | (fc % 32);
            else     v = bar_rgb_t[bar];
            return (b % 2 == 1) ? 8'(v % 256) : 8'((v / 256) % 256);
        end
        if (b % 2 == 0) return 8'h80;
        v = pat ? (col + row) % 256 : luma_t[bar];
        return 8'(v);
    endfunction

    // ---------------- capture-side monitor ----------------
    logic       prev_pclk, prev_vs, prev_href;
    bit         in_frame;
    bit         f_rgb, f_pat;
    int         cur_row, idx, frames_done, vs_rises, lines, rise_cnt, last_href_rise, per_err;
    logic [7:0] line_buf [ABYTES];
    logic [7:0] cap [ROWS][ABYTES];

    task automatic end_line();
        int bad;
        bad = -1;
        check_int("line_len", idx, ABYTES);
        if (!in_frame || cur_row >= ROWS) begin
            checks++;
            failures++;
            $display("FAIL stray_line got_row=%0d exp_rows=%0d in_frame=%0d", cur_row, ROWS, in_frame);
        end else begin
            for (int b = 0; b < ABYTES; b++) begin
                cap[cur_row][b] = line_buf[b];
                if (bad < 0 && line_buf[b] !== exp_byte(f_rgb, f_pat, frames_done, cur_row, b)) bad = b;
            end
            checks++;
            if (bad >= 0) begin
                failures++;
                $display("FAIL line_data frame=%0d row=%0d byte=%0d got=%h exp=%h",
                         frames_done, cur_row, bad, line_buf[bad],
                         exp_byte(f_rgb, f_pat, frames_done, cur_row, bad));
            end
        end
        lines++;
        cur_row++;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            prev_pclk   = 1'b0;
            prev_vs     = 1'b0;
            prev_href   = 1'b0;
            in_frame    = 1'b0;
            cur_row     = 0;
            idx         = 0;
            frames_done = 0;
            lines       = 0;
            vs_rises    = 0;
            rise_cnt    = 0;
            per_err     = 0;
        end else begin
            #1;
            if (frame_done) begin
                if (in_frame) begin
                    check_int("frame_lines", lines, ROWS);
                    check_int("vsync_pclks", vs_rises, VS * LINE);
                    check_int("line_period_err", per_err, 0);
                end
                in_frame = 1'b0;
                frames_done++;
            end
            if (vid.pclk && !prev_pclk) begin
                rise_cnt++;
                if (vid.vsync && !prev_vs) begin
                    in_frame = 1'b1;
                    f_rgb    = rgbmode;
                    f_pat    = pattern;
                    cur_row  = 0;
                    lines    = 0;
                    vs_rises = 0;
                    per_err  = 0;
                end
                if (vid.vsync) vs_rises++;
                if (vid.href) begin
                    if (!prev_href) begin
                        if (lines > 0 && rise_cnt - last_href_rise != LINE) per_err++;
                        last_href_rise = rise_cnt;
                        idx = 0;
                    end
                    if (idx < ABYTES) line_buf[idx] = vid.d;
                    idx++;
                end else if (prev_href) begin
                    end_line();
                end
                prev_vs   = vid.vsync;
                prev_href = vid.href;
            end
            prev_pclk = vid.pclk;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset(input bit rgb, input bit pat, input bit e);
        @(negedge clk);
        rgbmode = rgb;
        pattern = pat;
        en      = e;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int got = 0;
        int t   = 0;
        while (got < n && t < budget) begin
            @(negedge clk);
            t++;
            if (frame_done) got++;
        end
        if (got < n) begin
            checks++;
            failures++;
            $display("FAIL %s timeout got=%0d frames exp=%0d", name, got, n);
        end
    endtask

    task automatic wait_href(input int budget, input string name);
        int t = 0;
        while (vid.href !== 1'b1 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (vid.href !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s href_timeout got=%b exp=1", name, vid.href);
        end
    endtask

    typedef struct {
        bit         rgb;
        bit         pat;
        int         frm;
        int         row;
        int         bidx;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit rgb, input bit pat, input int frm, input int row,
                                input int bidx, input logic [7:0] exp);
        vec_t v;
        v.rgb = rgb; v.pat = pat; v.frm = frm; v.row = row; v.bidx = bidx; v.exp = exp;
        return v;
    endfunction

    initial begin
        int  fd_cnt, vs_after, toggles, t;
        logic pp;
        bit  have;
        vec_t pv;

        vecs.push_back(mk(1, 0, 0, 0,  0, 8'hFF));
        vecs.push_back(mk(1, 0, 0, 0,  1, 8'hFF));
        vecs.push_back(mk(1, 0, 0, 0,  4, 8'hFF));
        vecs.push_back(mk(1, 0, 0, 0,  5, 8'hE0));
        vecs.push_back(mk(1, 0, 0, 0, 30, 8'h00));
        vecs.push_back(mk(1, 0, 0, 0, 31, 8'h00));
        vecs.push_back(mk(1, 0, 0, 3, 20, 8'hF8));
        vecs.push_back(mk(1, 0, 0, 3, 21, 8'h00));
        vecs.push_back(mk(0, 0, 0, 0,  0, 8'h80));
        vecs.push_back(mk(0, 0, 0, 0,  1, 8'hEB));
        vecs.push_back(mk(0, 0, 0, 0,  2, 8'h80));
        vecs.push_back(mk(0, 0, 0, 0,  3, 8'hEB));
        vecs.push_back(mk(0, 0, 0, 2, 28, 8'h80));
        vecs.push_back(mk(0, 0, 0, 2, 29, 8'h10));
        vecs.push_back(mk(1, 1, 0, 1,  6, 8'h18));
        vecs.push_back(mk(1, 1, 0, 1,  7, 8'h20));
        vecs.push_back(mk(1, 1, 1, 1,  6, 8'h18));
        vecs.push_back(mk(1, 1, 1, 1,  7, 8'h21));
        vecs.push_back(mk(0, 1, 0, 2, 10, 8'h80));
        vecs.push_back(mk(0, 1, 0, 2, 11, 8'h07));
        vecs.push_back(mk(1, 1, 0, 3, 30, 8'h78));
        vecs.push_back(mk(1, 1, 0, 3, 31, 8'h60));

        // Reset state
        repeat (3) @(negedge clk);
        check_int("rst_pclk",  int'(vid.pclk),  0);
        check_int("rst_vsync", int'(vid.vsync), 0);
        check_int("rst_href",  int'(vid.href),  0);
        check8   ("rst_d",     vid.d,           8'h00);
        check_int("rst_done",  int'(frame_done), 0);
        check_int("rst_busy",  int'(busy),      0);

        // Table-driven pixel vectors; a fresh run only when the config changes
        have = 0;
        foreach (vecs[i]) begin
            if (!have || vecs[i].rgb != pv.rgb || vecs[i].pat != pv.pat || vecs[i].frm != pv.frm) begin
                do_reset(vecs[i].rgb, vecs[i].pat, 1'b1);
                wait_done(vecs[i].frm + 1, (vecs[i].frm + 2) * 700, "vec_run");
                pv   = vecs[i];
                have = 1;
            end
            check8($sformatf("vec%0d_r%0d_b%0d", i, vecs[i].row, vecs[i].bidx),
                   cap[vecs[i].row][vecs[i].bidx], vecs[i].exp);
        end

        // en dropped mid-ACTIVE: frame completes, one frame_done, busy falls with it
        do_reset(1'b1, 1'b0, 1'b1);
        wait_href(1200, "drop_en");
        check_int("busy_active", int'(busy), 1);
        en = 1'b0;
        fd_cnt = 0; vs_after = 0; toggles = 0; pp = vid.pclk;
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            if (vid.pclk !== pp) toggles++;
            pp = vid.pclk;
            if (frame_done) begin
                fd_cnt++;
                check_int("busy_fall", int'(busy), 0);
            end else if (fd_cnt > 0 && vid.vsync) begin
                vs_after++;
            end
        end
        check_int("drop_en_frames", fd_cnt, 1);
        check_int("drop_en_vsync", vs_after, 0);
        check_int("idle_pclk_toggles", int'(toggles > 1000), 1);
        check_int("idle_busy", int'(busy), 0);

        // 1-clk reset in the middle of a line, second frame of a ramp run
        do_reset(1'b1, 1'b1, 1'b1);
        wait_done(1, 1400, "midrst_pre");
        wait_href(1200, "midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_int("midrst_pclk",  int'(vid.pclk),  0);
        check_int("midrst_href",  int'(vid.href),  0);
        check_int("midrst_vsync", int'(vid.vsync), 0);
        check8   ("midrst_d",     vid.d,           8'h00);
        t = 0;
        while (vid.vsync !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_int("midrst_vsync_latency_ok", int'(t <= 2 * 2 * DIV), 1);
        wait_done(1, 1400, "midrst_post");
        check8("midrst_ramp_b6", cap[1][6], 8'h18);
        check8("midrst_ramp_b7", cap[1][7], 8'h20);

        // rgbmode toggled during ACTIVE takes effect on the next frame only
        do_reset(1'b1, 1'b0, 1'b1);
        wait_href(1200, "toggle");
        rgbmode = 1'b0;
        wait_done(1, 1400, "toggle_f0");
        check8("toggle_f0_b0", cap[3][0], 8'hFF);
        check8("toggle_f0_b1", cap[3][1], 8'hFF);
        wait_done(1, 1400, "toggle_f1");
        check8("toggle_f1_b0", cap[0][0], 8'h80);
        check8("toggle_f1_b1", cap[0][1], 8'hEB);

        // Randomized mode changes during href, checked by the monitor
        do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        for (int k = 0; k < 14; k++) begin
            repeat ($urandom_range(20, 400)) @(negedge clk);
            wait_href(1200, "rand");
            rgbmode = 1'($urandom_range(0, 1));
            pattern = 1'($urandom_range(0, 1));
        end
        wait_done(2, 1400, "rand_tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
